// File: rtl/blink_pkg.sv
// blink_pkg: pattern-generator select codes, sequencer state type and counter width helper.
package blink_pkg;
   localparam logic [2:0] SEL_UP    = 3'b000;
   localparam logic [2:0] SEL_DOWN  = 3'b001;
   localparam logic [2:0] SEL_LEFT  = 3'b010;
   localparam logic [2:0] SEL_RIGHT = 3'b011;
   localparam logic [2:0] SEL_BLANK = 3'b100;
   typedef enum logic [1:0] {RUN, PAUSED, BLANK} state_t;
   function automatic int cnt_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser, stability counter and rising-edge press pulse.
module btn_debounce
   import blink_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1250000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press
);
   localparam int CW = cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   logic [1:0] sync;
   logic [CW-1:0] cnt;
   always_ff @(posedge clk) begin
      if (reset) begin
         sync      <= '0;
         cnt       <= '0;
         btn_level <= 1'b0;
         btn_press <= 1'b0;
      end else begin
         sync      <= {sync[0], btn_raw};
         btn_press <= 1'b0;
         // any cycle agreeing with the accepted level restarts the stability count
         if (sync[1] == btn_level) cnt <= '0;
         else if (cnt == LAST) begin
            cnt       <= '0;
            btn_level <= sync[1];
            btn_press <= sync[1];
         end else cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/blink_mode_sequencer.sv
// blink_mode_sequencer: drives the LED pattern generator's select/pause from buttons
// and a dwell timer, inserting a blank interval before every mode change.
module blink_mode_sequencer
   import blink_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1250000,
   parameter int DWELL_CYCLES    = 250000000,
   parameter int BLANK_CYCLES    = 12500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_next,
   input  logic       btn_pause,
   input  logic       auto_en,
   output logic [2:0] select,
   output logic       pause,
   output logic       mode_change,
   output logic [1:0] mode
);
   localparam int DW = cnt_w(DWELL_CYCLES);
   localparam int BW = cnt_w(BLANK_CYCLES);
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
   localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
   state_t state;
   logic [DW-1:0] dwell;
   logic [BW-1:0] blank_cnt;
   logic next_press, pause_press, unused_next_level, unused_pause_level, advance;
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
      .clk(clk), .reset(reset), .btn_raw(btn_next),
      .btn_level(unused_next_level), .btn_press(next_press)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
      .clk(clk), .reset(reset), .btn_raw(btn_pause),
      .btn_level(unused_pause_level), .btn_press(pause_press)
   );
   // presses arriving in BLANK fall through and are lost; next beats pause
   assign advance = state != BLANK &&
                    (next_press || (state == RUN && auto_en && dwell == DWELL_LAST));
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RUN;
         mode        <= 2'd0;
         select      <= SEL_UP;
         pause       <= 1'b0;
         mode_change <= 1'b0;
         dwell       <= '0;
         blank_cnt   <= '0;
      end else begin
         mode_change <= advance;
         if (advance) begin
            state     <= BLANK;
            mode      <= mode + 1'b1;
            select    <= SEL_BLANK;
            pause     <= 1'b0;
            dwell     <= '0;
            blank_cnt <= '0;
         end else if (state == BLANK) begin
            blank_cnt <= blank_cnt == BLANK_LAST ? '0 : blank_cnt + 1'b1;
            if (blank_cnt == BLANK_LAST) begin
               state  <= RUN;
               select <= {1'b0, mode};
            end
         end else begin
            if (state == RUN) dwell <= auto_en ? dwell + 1'b1 : '0;
            if (pause_press) begin
               state <= state == RUN ? PAUSED : RUN;
               pause <= state == RUN;
            end
         end
      end
   end
endmodule

// File: tb/tb_blink_mode_sequencer.sv
// tb_blink_mode_sequencer: directed scenarios plus random stimulus, each cycle checked
// against a behavioural model built from remaining-blank and consecutive-sample counts.
module tb_blink_mode_sequencer;
   localparam int DEB = 4, DWELL = 20, BLANK = 3;
   logic clk = 0, reset = 1, btn_next = 0, btn_pause = 0, auto_en = 0;
   logic [2:0] select;
   logic pause, mode_change;
   logic [1:0] mode;
   int checks = 0, passed = 0;
   blink_mode_sequencer #(.DEBOUNCE_CYCLES(DEB), .DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)) dut (
      .clk(clk), .reset(reset), .btn_next(btn_next), .btn_pause(btn_pause),
      .auto_en(auto_en), .select(select), .pause(pause), .mode_change(mode_change), .mode(mode)
   );
   always #5 clk = ~clk;
   bit [1:0] m_mode;
   bit m_paused, m_mc;
   int m_dwell, m_blank;
   bit m_s1[2], m_s2[2], m_lvl[2], m_press[2];
   int m_run[2];
   // index 0 = next button, 1 = pause button
   function automatic void model_step(input bit r, input bit rn, input bit rp, input bit ae);
      bit raw[2];
      bit adv;
      raw[0] = rn;
      raw[1] = rp;
      if (r) begin
         m_mode = 0; m_paused = 0; m_mc = 0; m_dwell = 0; m_blank = 0;
         for (int b = 0; b < 2; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_press[b] = 0; m_run[b] = 0;
         end
         return;
      end
      adv = m_blank == 0 && (m_press[0] || (!m_paused && ae && m_dwell == DWELL - 1));
      m_mc = adv;
      if (adv) begin
         m_mode = m_mode + 2'd1; m_blank = BLANK; m_paused = 0; m_dwell = 0;
      end else if (m_blank > 0) m_blank--;
      else begin
         if (!m_paused) m_dwell = ae ? m_dwell + 1 : 0;
         if (m_press[1]) m_paused = !m_paused;
      end
      for (int b = 0; b < 2; b++) begin
         m_press[b] = 0;
         if (m_s2[b] != m_lvl[b]) begin
            m_run[b]++;
            if (m_run[b] == DEB) begin
               m_lvl[b] = m_s2[b]; m_press[b] = m_s2[b]; m_run[b] = 0;
            end
         end else m_run[b] = 0;
         m_s2[b] = m_s1[b];
         m_s1[b] = raw[b];
      end
   endfunction
   function automatic logic [6:0] exp_out();
      return {m_blank > 0 ? 3'b100 : {1'b0, m_mode}, m_paused, m_mc, m_mode};
   endfunction
   task automatic step();
      @(posedge clk);
      model_step(reset, btn_next, btn_pause, auto_en);
      #1;
   endtask
   task automatic do_reset();
      reset = 1; btn_next = 0; btn_pause = 0; auto_en = 0;
      step();
      reset = 0;
   endtask
   task automatic test_reset();
      reset = 1; btn_next = 1; btn_pause = 1; auto_en = 1;
      step(); step();
      checks++;
      if ({select, pause, mode_change, mode} !== 7'b0)
         $display("FAIL reset: got %b expected 0000000", {select, pause, mode_change, mode});
      else passed++;
      reset = 0; btn_next = 0; btn_pause = 0;
   endtask
   task automatic test_auto_cycle();
      int mcs = 0;
      do_reset();
      auto_en = 1;
      for (int i = 0; i < 4 * (DWELL + BLANK) + 3; i++) begin
         step();
         mcs += int'(mode_change);
         checks++;
         if ({select, pause, mode_change, mode} !== exp_out())
            $display("FAIL auto_cycle cyc %0d: got %b expected %b", i, {select, pause, mode_change, mode}, exp_out());
         else passed++;
      end
      checks++;
      if (mcs != 4 || mode !== 2'd0) $display("FAIL auto_cycle_count: got %0d changes mode %0d expected 4 mode 0", mcs, mode);
      else passed++;
   endtask
   task automatic test_next_bounce();
      int mcs = 0;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         btn_next = (i == 0) || (i >= 2 && i < 12);
         step();
         mcs += int'(mode_change);
         checks++;
         if ({select, pause, mode_change, mode} !== exp_out())
            $display("FAIL next_bounce cyc %0d: got %b expected %b", i, {select, pause, mode_change, mode}, exp_out());
         else passed++;
      end
      checks++;
      if (mcs != 1 || mode !== 2'd1) $display("FAIL next_bounce_count: got %0d changes mode %0d expected 1 mode 1", mcs, mode);
      else passed++;
   endtask
   task automatic test_pause();
      int early = 0;
      do_reset();
      auto_en = 1;
      for (int i = 0; i < 200; i++) begin
         btn_pause = (i >= 4 && i < 12) || (i >= 120 && i < 128);
         step();
         if (i < 120) early += int'(mode_change);
         checks++;
         if ({select, pause, mode_change, mode} !== exp_out())
            $display("FAIL pause cyc %0d: got %b expected %b", i, {select, pause, mode_change, mode}, exp_out());
         else passed++;
         if (i == 100) begin
            checks++;
            if (pause !== 1'b1 || select !== 3'b000) $display("FAIL pause_hold: got pause %b select %b expected 1 000", pause, select);
            else passed++;
         end
      end
      checks++;
      if (early != 0) $display("FAIL pause_no_advance: got %0d changes expected 0", early);
      else passed++;
   endtask
   task automatic test_back_to_back();
      int mcs = 0, pseen = 0;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         btn_next = i >= 2 && i < 12;
         btn_pause = btn_next;
         step();
         mcs += int'(mode_change);
         pseen += int'(pause);
         checks++;
         if ({select, pause, mode_change, mode} !== exp_out())
            $display("FAIL back_to_back cyc %0d: got %b expected %b", i, {select, pause, mode_change, mode}, exp_out());
         else passed++;
      end
      checks++;
      if (mcs != 1 || pseen != 0) $display("FAIL back_to_back_result: got %0d changes %0d paused cycles expected 1 0", mcs, pseen);
      else passed++;
   endtask
   task automatic test_next_in_blank();
      int mcs = 0;
      do_reset();
      auto_en = 1;
      for (int i = 0; i < 60; i++) begin
         btn_next = i >= 15 && i < 23;
         step();
         if (i < 40) mcs += int'(mode_change);
         checks++;
         if ({select, pause, mode_change, mode} !== exp_out())
            $display("FAIL next_in_blank cyc %0d: got %b expected %b", i, {select, pause, mode_change, mode}, exp_out());
         else passed++;
         if (i == 39) begin
            checks++;
            if (mcs != 1 || mode !== 2'd1) $display("FAIL next_in_blank_drop: got %0d changes mode %0d expected 1 mode 1", mcs, mode);
            else passed++;
         end
      end
   endtask
   task automatic test_reset_mid_blank();
      do_reset();
      for (int i = 0; i < 70; i++) begin
         btn_next = (i >= 2 && i < 12) || (i >= 30 && i < 40);
         reset = i == 37;
         auto_en = i >= 38;
         step();
         if (i == 36) begin
            checks++;
            if (select !== 3'b100 || mode !== 2'd2) $display("FAIL blank_mode2: got select %b mode %0d expected 100 2", select, mode);
            else passed++;
         end
         if (i == 37) begin
            checks++;
            if ({select, pause, mode_change, mode} !== 7'b0)
               $display("FAIL reset_mid_blank: got %b expected 0000000", {select, pause, mode_change, mode});
            else passed++;
         end
         checks++;
         if ({select, pause, mode_change, mode} !== exp_out())
            $display("FAIL reset_mid_blank cyc %0d: got %b expected %b", i, {select, pause, mode_change, mode}, exp_out());
         else passed++;
      end
      reset = 0;
   endtask
   task automatic test_random();
      do_reset();
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(11) == 0) btn_next = ~btn_next;
         if ($urandom_range(13) == 0) btn_pause = ~btn_pause;
         if ($urandom_range(59) == 0) auto_en = ~auto_en;
         reset = $urandom_range(399) == 0;
         step();
         checks++;
         if ({select, pause, mode_change, mode} !== exp_out())
            $display("FAIL random cyc %0d: got %b expected %b", i, {select, pause, mode_change, mode}, exp_out());
         else passed++;
      end
      reset = 0;
   endtask
   initial begin
      test_reset();
      test_auto_cycle();
      test_next_bounce();
      test_pause();
      test_back_to_back();
      test_next_in_blank();
      test_reset_mid_blank();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
